pio_out_pulse: RTL and testbench

- Parametrised Avalon-MM slave output port; next generation of the system's 8-bit output PIO.
- Adds configurable width, atomic bit set/clear, and a hardware pulse generator: selected bits auto-clear after a programmable cycle count.
- Sits on the Nios II data master interconnect and drives user logic (LEDs, strobes, filter control lines) through out_port.

---
 rtl/pio_out_pulse.sv | 126 ++++++++++++
 tb/tb_pio_out_pulse.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pio_out_pulse.sv
// pio_out_pulse: Avalon-MM slave output port with atomic bit set/clear and
// a hardware pulse generator. Bits selected by pulse_mask are cleared
// automatically a programmable number of cycles after a DATA or OUTSET
// write sets any of them.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-high reset
//   address    word offset: 0 DATA, 1 PULSE_MASK, 2 PULSE_LEN, 3 STATUS,
//              4 OUTSET, 5 OUTCLEAR, 6-7 reserved
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (low DATA_WIDTH / CNT_WIDTH bits used)
//   readdata   combinational, zero-extended read data (decoded from address)
//   out_port   data register contents
//   pulse_busy high while the pulse down-counter is non-zero
module pio_out_pulse #(
  parameter int unsigned                 DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0]       RESET_VALUE = '0,
  parameter int unsigned                 CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_MASK     = 3'd1,
    ADDR_LEN      = 3'd2,
    ADDR_STATUS   = 3'd3,
    ADDR_OUTSET   = 3'd4,
    ADDR_OUTCLEAR = 3'd5
  } addr_e;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  len_q,  len_d;
  logic [CNT_WIDTH-1:0]  cnt_q,  cnt_d;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [CNT_WIDTH-1:0]  wd_cnt;
  logic                  set_wr;
  logic                  load;
  logic                  expiry;
  logic [DATA_WIDTH-1:0] clr_mask;
  logic [CNT_WIDTH-1:0]  len_eff;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign wd_cnt    = writedata[CNT_WIDTH-1:0];
  assign unused_wd = &{1'b0, writedata};

  // DATA and OUTSET are the only writes that can start a pulse
  assign set_wr  = wr & ((address == ADDR_DATA) | (address == ADDR_OUTSET));
  assign load    = set_wr & (|(wd_data & mask_q));
  assign len_eff = (len_q == '0) ? CNT_WIDTH'(1) : len_q;

  // Expiry is the 1->0 step; a reload at that moment is not an expiry.
  // The clear uses the mask currently held, so a same-cycle mask write
  // only affects later pulses.
  assign expiry   = (cnt_q == CNT_WIDTH'(1)) & ~load;
  assign clr_mask = expiry ? mask_q : '0;

  always_comb begin
    data_d = data_q & ~clr_mask;
    mask_d = mask_q;
    len_d  = len_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_d = wd_data;
        ADDR_MASK:     mask_d = wd_data;
        ADDR_LEN:      len_d  = wd_cnt;
        ADDR_OUTSET:   data_d = data_q | wd_data;
        ADDR_OUTCLEAR: data_d = data_q & ~wd_data & ~clr_mask;
        default:       ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = len_eff;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      mask_q <= '0;
      len_q  <= CNT_WIDTH'(1);
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[DATA_WIDTH-1:0] = data_q;
      ADDR_MASK:   readdata[DATA_WIDTH-1:0] = mask_q;
      ADDR_LEN:    readdata[CNT_WIDTH-1:0]  = len_q;
      ADDR_STATUS: readdata[CNT_WIDTH-1:0]  = cnt_q;
      default:     readdata = '0;
    endcase
  end

  assign out_port   = data_q;
  assign pulse_busy = (cnt_q != '0);

endmodule

// File: tb/tb_pio_out_pulse.sv
// Directed bench for pio_out_pulse (DATA_WIDTH=8, RESET_VALUE=8'hA5).
// Inputs change on the falling edge; outputs are sampled 1ns after it.
module tb_pio_out_pulse;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;

  int vectors = 0;
  int miscompares = 0;

  pio_out_pulse #(
    .DATA_WIDTH (8),
    .RESET_VALUE(8'hA5),
    .CNT_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .pulse_busy(pulse_busy)
  );

  always #5 clk = ~clk;

  // Single-cycle write; returns at the falling edge after the write edge
  // with address left pointing at STATUS.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 3'd3;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (out_port !== 8'hA5) begin miscompares++; $display("FAIL reset_out got %h exp a5", out_port); end
    vectors++; if (pulse_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", pulse_busy); end
    vectors++; if (readdata !== 32'h000000A5) begin miscompares++; $display("FAIL reset_rd0 got %h exp 000000a5", readdata); end
    address = 3'd3; #1;
    vectors++; if (readdata !== 32'h0) begin miscompares++; $display("FAIL reset_rd3 got %h exp 0", readdata); end
    address = 3'd2; #1;
    vectors++; if (readdata !== 32'h1) begin miscompares++; $display("FAIL reset_len got %h exp 1", readdata); end
    @(negedge clk); reset = 1'b0;
    bus_write(3'd0, 32'h3C);
    vectors++; if (out_port !== 8'h3C) begin miscompares++; $display("FAIL data_wr got %h exp 3c", out_port); end
  endtask

  task automatic test_set_clear();
    bus_write(3'd0, 32'h0F);
    bus_write(3'd4, 32'hF0);
    vectors++; if (out_port !== 8'hFF) begin miscompares++; $display("FAIL outset got %h exp ff", out_port); end
    bus_write(3'd5, 32'h81);
    vectors++; if (out_port !== 8'h7E) begin miscompares++; $display("FAIL outclear got %h exp 7e", out_port); end
    for (int a = 4; a < 8; a++) begin
      address = 3'(a); #1;
      vectors++; if (readdata !== 32'h0) begin miscompares++; $display("FAIL rd_wo_res addr %0d got %h exp 0", a, readdata); end
    end
    bus_write(3'd6, 32'hFF);
    vectors++; if (out_port !== 8'h7E) begin miscompares++; $display("FAIL reserved_wr got %h exp 7e", out_port); end
  endtask

  task automatic test_pulse();
    bus_write(3'd1, 32'h01);
    bus_write(3'd2, 32'h04);
    address = 3'd1; #1;
    vectors++; if (readdata !== 32'h1) begin miscompares++; $display("FAIL rd_mask got %h exp 1", readdata); end
    address = 3'd2; #1;
    vectors++; if (readdata !== 32'h4) begin miscompares++; $display("FAIL rd_len got %h exp 4", readdata); end
    bus_write(3'd0, 32'h11);
    vectors++; if (out_port !== 8'h11 || readdata !== 32'd4 || pulse_busy !== 1'b1)
      begin miscompares++; $display("FAIL pulse_start out %h st %0d busy %b exp 11/4/1", out_port, readdata, pulse_busy); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (out_port !== ((i < 4) ? 8'h11 : 8'h10) || readdata !== 32'(4 - i) || pulse_busy !== (i < 4))
        begin miscompares++; $display("FAIL pulse_cyc%0d out %h st %0d busy %b exp %h/%0d/%b", i, out_port, readdata, pulse_busy, (i < 4) ? 8'h11 : 8'h10, 4 - i, i < 4); end
    end
  endtask

  task automatic test_retrigger();
    bus_write(3'd2, 32'h0);
    bus_write(3'd1, 32'h80);
    bus_write(3'd4, 32'h80);
    vectors++; if (out_port !== 8'h90 || pulse_busy !== 1'b1) begin miscompares++; $display("FAIL len0_start out %h busy %b exp 90/1", out_port, pulse_busy); end
    @(negedge clk); #1;
    vectors++; if (out_port !== 8'h10 || pulse_busy !== 1'b0) begin miscompares++; $display("FAIL len0_end out %h busy %b exp 10/0", out_port, pulse_busy); end
    bus_write(3'd2, 32'h5);
    bus_write(3'd0, 32'h80);
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    vectors++; if (readdata !== 32'd2 || out_port !== 8'h80) begin miscompares++; $display("FAIL retrig_pre st %0d out %h exp 2/80", readdata, out_port); end
    bus_write(3'd0, 32'h80);
    vectors++; if (readdata !== 32'd5) begin miscompares++; $display("FAIL retrig_load st %0d exp 5", readdata); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (out_port !== ((i < 5) ? 8'h80 : 8'h00) || readdata !== 32'(5 - i))
        begin miscompares++; $display("FAIL retrig_cyc%0d out %h st %0d exp %h/%0d", i, out_port, readdata, (i < 5) ? 8'h80 : 8'h00, 5 - i); end
    end
  endtask

  task automatic test_collision();
    bus_write(3'd1, 32'h02);
    bus_write(3'd2, 32'h03);
    bus_write(3'd0, 32'h02);
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (readdata !== 32'd1) begin miscompares++; $display("FAIL coll1_pre st %0d exp 1", readdata); end
    bus_write(3'd0, 32'h04);
    vectors++; if (out_port !== 8'h04 || readdata !== 32'd0 || pulse_busy !== 1'b0)
      begin miscompares++; $display("FAIL coll_data out %h st %0d busy %b exp 04/0/0", out_port, readdata, pulse_busy); end
    @(negedge clk); #1;
    vectors++; if (out_port !== 8'h04) begin miscompares++; $display("FAIL coll_data_hold got %h exp 04", out_port); end
    bus_write(3'd0, 32'h07);
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (readdata !== 32'd1) begin miscompares++; $display("FAIL coll2_pre st %0d exp 1", readdata); end
    bus_write(3'd5, 32'h01);
    vectors++; if (out_port !== 8'h04 || readdata !== 32'd0)
      begin miscompares++; $display("FAIL coll_clear out %h st %0d exp 04/0", out_port, readdata); end
  endtask

  task automatic test_reset_mid_pulse();
    bus_write(3'd1, 32'h01);
    bus_write(3'd2, 32'h04);
    bus_write(3'd0, 32'hFF);
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (readdata !== 32'd2 || out_port !== 8'hFF) begin miscompares++; $display("FAIL rst_pre st %0d out %h exp 2/ff", readdata, out_port); end
    #1 reset = 1'b1;
    #1;
    vectors++; if (out_port !== 8'hA5 || readdata !== 32'd0 || pulse_busy !== 1'b0)
      begin miscompares++; $display("FAIL rst_async out %h st %0d busy %b exp a5/0/0", out_port, readdata, pulse_busy); end
    @(negedge clk); reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (out_port !== 8'hA5 || pulse_busy !== 1'b0)
        begin miscompares++; $display("FAIL rst_after%0d out %h busy %b exp a5/0", i, out_port, pulse_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_pulse();
    test_retrigger();
    test_collision();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
